// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit that produces the HI/LO pair
// for mult, multu, div and divu. It uses a start/busy/done handshake with the
// control unit. A divide-by-zero is flagged for one cycle on div_zero.
//
// Ports:
//   clock    - rising-edge clock
//   reset    - synchronous, active-low
//   start    - request, sampled only while idle (with op, src_a, src_b)
//   op       - 00 mult, 01 multu, 10 div, 11 divu
//   src_a    - multiplicand / dividend
//   src_b    - multiplier / divisor
//   busy     - operation in flight
//   done     - one-cycle completion pulse; hi/lo valid in the same cycle
//   div_zero - one-cycle pulse with done when a divide has a zero divisor
//   hi       - product upper half / remainder
//   lo       - product lower half / quotient
//
// Build option: define MULTDIV_UNSIGNED_EN to support multu/divu as unsigned
// operations. Without it, op[0] is ignored and every operation is signed.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PREP = 2'd1;
  localparam logic [1:0] CALC = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;

  logic [1:0]         state;
  logic [1:0]         stateNext;
  logic               busyNext;
  logic               doneNext;
  logic               divZeroNext;

  logic               opDiv;
  logic               isSigned;
  logic               divByZero;
  logic [WIDTH-1:0]   aReg;
  logic [WIDTH-1:0]   bReg;
  logic [WIDTH-1:0]   prepMagA;
  logic [WIDTH-1:0]   prepMagB;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic               signQ;
  logic               signR;
  logic [CNT_W-1:0]   count;

  // Multiply accumulator: multiplier in the low half, product builds from the top.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     addSum;

  // Divide: quo shifts the dividend out and the quotient in; rem holds the
  // partial remainder, widened by one bit for the trial subtraction.
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH:0]     trialRem;
  logic [WIDTH:0]     subRem;
  logic               trialFits;

  logic [2*WIDTH-1:0] prodFinal;
  logic [WIDTH-1:0]   quoFinal;
  logic [WIDTH-1:0]   remFinal;

`ifdef MULTDIV_UNSIGNED_EN
  logic               opUnsigned;

  assign isSigned = ~opUnsigned;
`else
  logic               unusedOp;

  assign isSigned = 1'b1;
  assign unusedOp = op[0];
`endif

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) naturally.
  assign prepMagA  = (isSigned && aReg[WIDTH-1]) ? -aReg : aReg;
  assign prepMagB  = (isSigned && bReg[WIDTH-1]) ? -bReg : bReg;
  assign divByZero = opDiv && (bReg == '0);

  // One shift-add step.
  assign addSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, magA} : '0);

  // One restoring-division step.
  assign trialRem  = {rem, quo[WIDTH-1]};
  assign trialFits = (trialRem >= {1'b0, magB});
  assign subRem    = trialRem - {1'b0, magB};

  // Sign correction; MIN / -1 wraps to MIN with a zero remainder on its own.
  assign prodFinal = signQ ? -acc : acc;
  assign quoFinal  = signQ ? -quo : quo;
  assign remFinal  = signR ? -rem : rem;

  // Control state and handshake registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= stateNext;
      busy     <= busyNext;
      done     <= doneNext;
      div_zero <= divZeroNext;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    stateNext   = state;
    busyNext    = busy;
    doneNext    = 1'b0;
    divZeroNext = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = PREP;
          busyNext  = 1'b1;
        end
      end
      PREP: begin
        if (divByZero) begin
          stateNext   = IDLE;
          busyNext    = 1'b0;
          doneNext    = 1'b1;
          divZeroNext = 1'b1;
        end else begin
          stateNext = CALC;
        end
      end
      CALC: begin
        if (count == '0) begin
          stateNext = FIX;
        end
      end
      FIX: begin
        stateNext = IDLE;
        busyNext  = 1'b0;
        doneNext  = 1'b1;
      end
      default: begin
        stateNext = IDLE;
        busyNext  = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, preparation, iteration and result write-back.
  always_ff @(posedge clock) begin
    if (!reset) begin
      opDiv <= 1'b0;
`ifdef MULTDIV_UNSIGNED_EN
      opUnsigned <= 1'b0;
`endif
      aReg  <= '0;
      bReg  <= '0;
      magA  <= '0;
      magB  <= '0;
      signQ <= 1'b0;
      signR <= 1'b0;
      count <= '0;
      acc   <= '0;
      quo   <= '0;
      rem   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opDiv <= op[1];
`ifdef MULTDIV_UNSIGNED_EN
            opUnsigned <= op[0];
`endif
            aReg <= src_a;
            bReg <= src_b;
          end
        end
        PREP: begin
          magA  <= prepMagA;
          magB  <= prepMagB;
          signQ <= isSigned && (aReg[WIDTH-1] ^ bReg[WIDTH-1]);
          signR <= isSigned && aReg[WIDTH-1];
          count <= CNT_W'(WIDTH - 1);
          acc   <= {{WIDTH{1'b0}}, prepMagB};
          quo   <= prepMagA;
          rem   <= '0;
        end
        CALC: begin
          count <= count - CNT_W'(1);
          if (opDiv) begin
            rem <= trialFits ? subRem[WIDTH-1:0] : trialRem[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], trialFits};
          end else begin
            acc <= {addSum, acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (opDiv) begin
            hi <= remFinal;
            lo <= quoFinal;
          end else begin
            hi <= prodFinal[2*WIDTH-1:WIDTH];
            lo <= prodFinal[WIDTH-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
